// File: rtl/bus_arbiter16.sv
// bus_arbiter16: two-requester round-robin arbiter for the shared 16-bit bus.
//
// Purpose:
//   Requesters A and B share one Mux16 data path. The arbiter drives the mux
//   select and registers the selected word onto the shared output bus together
//   with a valid strobe. It caps each grant at MAX_BURST consecutive words
//   while the other side is waiting, so neither requester can starve the other.
//
// Handshake:
//   reqX acts as "valid" and gntX acts as "ready". A word moves on any clock
//   edge where the owner's req is high while its gnt is high. A requester
//   holds reqX and dataX stable until it sees its own transfer. The word then
//   appears on out with outValid=1 one cycle after the transfer edge.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   reqA/reqB in   bus requests
//   dataA     in   requester A word (Mux16 X input)
//   dataB     in   requester B word (Mux16 Y input)
//   gntA/gntB out  registered-state grant decode
//   sel       out  Mux16 select (0 = dataA, 1 = dataB)
//   out       out  registered transferred word
//   outValid  out  out holds a word transferred on the previous edge
module bus_arbiter16 #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqA,
  input  logic             reqB,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             gntA,
  output logic             gntB,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             outValid
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_A = 2'd1;
  localparam logic [1:0] S_GRANT_B = 2'd2;

  // Count value reached on the final word of a full burst.
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic             last_b_q, last_b_d;     // 1: B was served last
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] mux_y;

  assign gntA     = (state_q == S_GRANT_A);
  assign gntB     = (state_q == S_GRANT_B);
  assign sel      = (state_q == S_GRANT_B);
  assign out      = out_q;
  assign outValid = out_valid_q;

  // The Mux16 itself: the only path by which requester data reaches out.
  assign mux_y = sel ? dataB : dataA;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    last_b_d    = last_b_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        count_d = 4'd0;
        // Ties go to whichever side was not served last.
        if (reqA && reqB) begin
          state_d = last_b_q ? S_GRANT_A : S_GRANT_B;
        end else if (reqA) begin
          state_d = S_GRANT_A;
        end else if (reqB) begin
          state_d = S_GRANT_B;
        end
      end

      S_GRANT_A: begin
        if (!reqA) begin
          // Owner released: hand straight over or fall back to idle.
          state_d  = reqB ? S_GRANT_B : S_IDLE;
          last_b_d = 1'b0;
          count_d  = 4'd0;
        end else begin
          out_d       = mux_y;
          out_valid_d = 1'b1;
          if (count_q == BURST_LAST) begin
            // Burst cap reached; only yield if B is actually waiting.
            count_d = 4'd0;
            if (reqB) begin
              state_d  = S_GRANT_B;
              last_b_d = 1'b0;
            end
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end

      S_GRANT_B: begin
        if (!reqB) begin
          state_d  = reqA ? S_GRANT_A : S_IDLE;
          last_b_d = 1'b1;
          count_d  = 4'd0;
        end else begin
          out_d       = mux_y;
          out_valid_d = 1'b1;
          if (count_q == BURST_LAST) begin
            count_d = 4'd0;
            if (reqA) begin
              state_d  = S_GRANT_A;
              last_b_d = 1'b1;
            end
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= 4'd0;
      last_b_q    <= 1'b1;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_b_q    <= last_b_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter16.sv
// tb_bus_arbiter16: bench for bus_arbiter16 with a behavioural owner/run model,
// a transferred-word expected queue, directed literal scenarios and a
// randomized request/reset phase.
module tb_bus_arbiter16;

  localparam int WIDTH     = 16;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             reqA, reqB;
  logic [WIDTH-1:0] dataA, dataB;
  logic             gntA, gntB, sel, outValid;
  logic [WIDTH-1:0] out;

  always #5 clk = ~clk;

  bus_arbiter16 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .reset    (reset),
    .reqA     (reqA),
    .reqB     (reqB),
    .dataA    (dataA),
    .dataB    (dataB),
    .gntA     (gntA),
    .gntB     (gntB),
    .sel      (sel),
    .out      (out),
    .outValid (outValid)
  );

  // ---------------- counters / scoreboard ----------------
  int               n_vec  = 0;
  int               n_miss = 0;
  bit               cmp_en = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  // Model: who owns the bus (0 none, 1 A, 2 B), words in the current run,
  // who was served last, and the expected registered output.
  int               m_owner = 0;
  int               m_run   = 0;
  int               m_last  = 2;
  logic [WIDTH-1:0] m_out   = '0;
  logic             m_valid = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  initial begin : model_p
    int               other;
    bit               rq[3];
    logic [WIDTH-1:0] dt[3];
    forever begin
      @(posedge clk);
      rq[0] = 1'b0;  rq[1] = reqA;  rq[2] = reqB;
      dt[0] = '0;    dt[1] = dataA; dt[2] = dataB;
      if (reset === 1'b1) begin
        m_owner = 0;
        m_run   = 0;
        m_last  = 2;
        m_out   = '0;
        m_valid = 1'b0;
        exp_q.delete();
      end else if (m_owner == 0) begin
        m_valid = 1'b0;
        if (rq[1] && rq[2]) m_owner = 3 - m_last;
        else if (rq[1])     m_owner = 1;
        else if (rq[2])     m_owner = 2;
      end else begin
        other = 3 - m_owner;
        if (rq[m_owner]) begin
          m_out   = dt[m_owner];
          m_valid = 1'b1;
          exp_q.push_back(m_out);
          m_run++;
          if (m_run == MAX_BURST) begin
            m_run = 0;
            if (rq[other]) begin
              m_last  = m_owner;
              m_owner = other;
            end
          end
        end else begin
          m_valid = 1'b0;
          m_run   = 0;
          m_last  = m_owner;
          m_owner = rq[other] ? other : 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare_p
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("gntA",     32'(gntA),     32'(m_owner == 1));
        check("gntB",     32'(gntB),     32'(m_owner == 2));
        check("sel",      32'(sel),      32'(m_owner == 2));
        check("outValid", 32'(outValid), 32'(m_valid));
        check("out",      32'(out),      32'(m_out));
        if (outValid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(1), 32'(0));
          end else begin
            w = exp_q.pop_front();
            check("sb_word", 32'(out), 32'(w));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change right after a falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int               rec_ga[10];
  int               rec_v[10];
  int               rec_o[10];
  int               exp_ga[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
  int               exp_v[10]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int               exp_o[10]  = '{0, 45, 45, 45, 45, 89, 89, 89, 89, 45};

  initial begin
    int pa, pb;
    reset = 1'b1;
    reqA  = 1'b1;
    reqB  = 1'b1;
    dataA = 16'd45;
    dataB = 16'd89;

    // Reset held for two cycles with both requesting.
    step();
    cmp_en = 1'b1;
    step();
    check("rst_gntA",     32'(gntA),     0);
    check("rst_gntB",     32'(gntB),     0);
    check("rst_outValid", 32'(outValid), 0);
    check("rst_out",      32'(out),      0);
    reset = 1'b0;

    // Contention: A wins the first tie, 4 words each, no gap, back to A.
    for (int i = 0; i < 10; i++) begin
      step();
      rec_ga[i] = int'(gntA);
      rec_v[i]  = int'(outValid);
      rec_o[i]  = int'(out);
    end
    for (int i = 0; i < 10; i++) begin
      check($sformatf("cont_gntA[%0d]", i), 32'(rec_ga[i]), 32'(exp_ga[i]));
      check($sformatf("cont_valid[%0d]", i), 32'(rec_v[i]), 32'(exp_v[i]));
      check($sformatf("cont_out[%0d]", i), 32'(rec_o[i]), 32'(exp_o[i]));
    end

    // Single requester A, sustained one word per cycle past the burst cap.
    reqA = 1'b1; reqB = 1'b0; dataA = 16'd45;
    do_reset();
    step();
    check("single_gntA_first",  32'(gntA),     1);
    check("single_valid_first", 32'(outValid), 0);
    step();
    check("single_out_45", 32'(out),      45);
    check("single_valid",  32'(outValid), 1);
    for (int i = 0; i < 8; i++) begin
      dataA = 16'(100 + i);
      step();
      check($sformatf("single_out[%0d]", i), 32'(out), 32'(100 + i));
      check($sformatf("single_gntA[%0d]", i), 32'(gntA), 1);
    end

    // Early release by B after two words; A picks up after one bubble.
    reqA = 1'b0; reqB = 1'b1; dataB = 16'd7;
    do_reset();
    step();
    check("early_gntB", 32'(gntB), 1);
    step();
    step();
    check("early_out_b", 32'(out), 7);
    reqB = 1'b0; reqA = 1'b1; dataA = 16'd23;
    step();
    check("early_bubble_valid", 32'(outValid), 0);
    check("early_gntA",         32'(gntA),     1);
    step();
    check("early_out_23", 32'(out),      23);
    check("early_valid",  32'(outValid), 1);

    // Tie after idle with B last served (fresh reset): A wins.
    reqA = 1'b0; reqB = 1'b0;
    do_reset();
    step();
    reqA = 1'b1; reqB = 1'b1;
    step();
    check("tie_reset_gntA", 32'(gntA), 1);

    // Tie after an A burst: B wins.
    reqA = 1'b1; reqB = 1'b0; dataA = 16'd11;
    do_reset();
    step();
    step();
    step();
    reqA = 1'b0;
    step();
    check("tie_idle_gntA", 32'(gntA), 0);
    check("tie_idle_gntB", 32'(gntB), 0);
    step();
    reqA = 1'b1; reqB = 1'b1;
    step();
    check("tie_after_a_gntB", 32'(gntB), 1);
    check("tie_after_a_gntA", 32'(gntA), 0);

    // Reset mid-burst in GRANT_B: word 98 must never appear.
    reqA = 1'b0; reqB = 1'b1; dataB = 16'd97;
    do_reset();
    step();
    step();
    check("midrst_out_97", 32'(out), 97);
    dataB = 16'd98;
    reset = 1'b1;
    step();
    check("midrst_gntB",  32'(gntB),     0);
    check("midrst_valid", 32'(outValid), 0);
    check("midrst_out",   32'(out),      0);
    reset = 1'b0;
    reqB  = 1'b0;
    step();

    // Randomized phase: request densities change every 64 cycles.
    pa = 5; pb = 5;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 64) == 0) begin
        pa = int'($urandom_range(0, 10));
        pb = int'($urandom_range(0, 10));
      end
      reqA  = (int'($urandom_range(0, 9)) < pa);
      reqB  = (int'($urandom_range(0, 9)) < pb);
      dataA = 16'($urandom);
      dataB = 16'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; reqA = 1'b0; reqB = 1'b0;
    step();
    step();
    check("sb_drain", 32'(exp_q.size()), 0);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
